// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between the fetch port and the data port.
// Data wins over fetch, but only for MAX_DATA_RUN grants in a row while fetch is waiting.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic             owner;     // 1 = data port owns the outstanding read
  logic [LAT_W-1:0] lat_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             rd_issue;
  logic             rd_done;

  assign rd_issue = mem_en & ~mem_we;
  assign rd_done  = ~rst & (state == BUSY) & (lat_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_issue) state_nxt = BUSY;
      BUSY:    if (lat_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!rst) begin
      if (state == IDLE) begin
        d_gnt  = d_req & (~if_req | (run_cnt < RUN_MAX));
        if_gnt = if_req & ~d_gnt;
      end
      if (d_gnt) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_we ? d_wdata : '0;
      end else if (if_gnt) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      if (rd_done) begin
        if (owner) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
    end
  end

  assign stall_if = ~rst & if_req & ~if_gnt;
  assign stall_d  = ~rst & d_req & ~d_gnt;

  // Stores finish in their issue cycle, so only reads load the latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= 1'b0;
      lat_cnt <= '0;
    end else if (rd_issue) begin
      owner   <= d_gnt;
      lat_cnt <= LAT_INIT;
    end else if (state == BUSY && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Counts back-to-back data grants only while fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (rst)                              run_cnt <= '0;
    else if (~if_req | if_gnt)            run_cnt <= '0;
    else if (d_gnt && run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), only one active at a
// time; a timestamp-based model predicts every output each cycle, plus literal spot checks.
module tb_mem_port_arbiter;
  localparam int MAX_RUN = 4;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall_if;
    logic        stall_d;
  } outs_t;

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, rst1, rst3;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  outs_t       o1, o3, o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  assign rst1 = rst | sel;
  assign rst3 = rst | ~sel;
  assign o    = sel ? o3 : o1;

  mem_port_arbiter #(.MEM_LAT(1), .MAX_DATA_RUN(MAX_RUN)) u1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o1.if_gnt),
    .if_rvalid(o1.if_rvalid), .if_rdata(o1.if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(o1.d_gnt), .d_rvalid(o1.d_rvalid), .d_rdata(o1.d_rdata),
    .mem_en(o1.mem_en), .mem_we(o1.mem_we), .mem_addr(o1.mem_addr),
    .mem_wdata(o1.mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(o1.stall_if), .stall_d(o1.stall_d)
  );

  mem_port_arbiter #(.MEM_LAT(3), .MAX_DATA_RUN(MAX_RUN)) u3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o3.if_gnt),
    .if_rvalid(o3.if_rvalid), .if_rdata(o3.if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(o3.d_gnt), .d_rvalid(o3.d_rvalid), .d_rdata(o3.d_rdata),
    .mem_en(o3.mem_en), .mem_we(o3.mem_we), .mem_addr(o3.mem_addr),
    .mem_wdata(o3.mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(o3.stall_if), .stall_d(o3.stall_d)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Memory: read data is only valid exactly MEM_LAT cycles after the issue, junk otherwise.
  int          mi_cyc = -100;
  logic [31:0] mi_addr = '0;
  always_comb begin
    if (cyc == mi_cyc + (sel ? 3 : 1)) mem_rdata = memval(mi_addr);
    else                               mem_rdata = {16'hBAD0, cyc[15:0]};
  end

  // Model state: earliest cycle an issue may happen, and the scheduled read return.
  int          m_free = 0;
  int          m_ret  = -1;
  bit          m_ret_d;
  logic [31:0] m_ret_addr;
  int          m_run  = 0;
  logic        e_dg, e_ig, e_en, e_we, e_rv;
  logic [31:0] e_addr, e_wd;

  always @(negedge clk) begin
    e_dg = 0; e_ig = 0; e_en = 0; e_we = 0; e_rv = 0; e_addr = '0; e_wd = '0;
    if (!rst) begin
      e_dg   = (cyc >= m_free) && d_req && (!if_req || m_run < MAX_RUN);
      e_ig   = (cyc >= m_free) && if_req && !e_dg;
      e_en   = e_dg || e_ig;
      e_we   = e_dg && d_we;
      e_addr = e_dg ? d_addr : (e_ig ? if_addr : 32'h0);
      e_wd   = e_we ? d_wdata : 32'h0;
      e_rv   = (cyc == m_ret);
    end
    chk("if_gnt",    o.if_gnt, e_ig);
    chk("d_gnt",     o.d_gnt, e_dg);
    chk("mem_en",    o.mem_en, e_en);
    chk("mem_we",    o.mem_we, e_we);
    chk("mem_addr",  o.mem_addr, e_addr);
    chk("mem_wdata", o.mem_wdata, e_wd);
    chk("if_rvalid", o.if_rvalid, e_rv && !m_ret_d);
    chk("if_rdata",  o.if_rdata, (e_rv && !m_ret_d) ? memval(m_ret_addr) : 32'h0);
    chk("d_rvalid",  o.d_rvalid, e_rv && m_ret_d);
    chk("d_rdata",   o.d_rdata, (e_rv && m_ret_d) ? memval(m_ret_addr) : 32'h0);
    chk("stall_if",  o.stall_if, !rst && if_req && !e_ig);
    chk("stall_d",   o.stall_d, !rst && d_req && !e_dg);
    chk("inactive_zero", {31'h0, (sel ? o1 : o3) != '0}, 32'h0);
    if (rst) begin
      m_free = cyc + 1;
      m_ret  = -1;
      m_run  = 0;
    end else begin
      if (e_en && !e_we) begin
        m_ret      = cyc + (sel ? 3 : 1);
        m_ret_d    = e_dg;
        m_ret_addr = e_addr;
        m_free     = m_ret + 1;
      end
      if (!if_req || e_ig)             m_run = 0;
      else if (e_dg && m_run < MAX_RUN) m_run++;
    end
    if (o.mem_en && !o.mem_we) begin
      mi_cyc  = cyc;
      mi_addr = o.mem_addr;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req = 0; d_req = 0; d_we = 0;
  endtask

  task automatic xfer(input vec_t v);
    int t = 0;
    if (v.d) begin d_req = 1; d_we = v.we; d_addr = v.a; d_wdata = v.wd; end
    else     begin if_req = 1; if_addr = v.a; end
    #1;
    while (!(v.d ? o.d_gnt : o.if_gnt)) begin
      step(); #1; t++;
      if (t > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL gnt_timeout: got no grant want grant within 20 cycles (cyc %0d)", cyc);
        break;
      end
    end
    step();
    idle_in();
  endtask

  vec_t vl[6] = '{
    '{1'b1, 1'b0, 32'h0000_0080, 32'h0},
    '{1'b0, 1'b0, 32'h0000_0104, 32'h0},
    '{1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678},
    '{1'b1, 1'b0, 32'h0000_0044, 32'h0},
    '{1'b0, 1'b0, 32'h0000_0108, 32'h0},
    '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5}
  };

  logic [6:0] dg, ig;
  logic       seen;

  initial begin
    // T1/T4/T2 on the MEM_LAT=1 instance
    rst = 1; sel = 0; if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    step(); #1;
    chk("t1_rst_dgnt", o.d_gnt, 0);
    chk("t1_rst_memen", o.mem_en, 0);
    chk("t1_rst_stall", o.stall_d, 0);
    step();
    rst = 0; #1;
    chk("t1_first_dgnt", o.d_gnt, 1);
    chk("t4_mem_we", o.mem_we, 1);
    chk("t4_addr", o.mem_addr, 32'h40);
    chk("t4_wdata", o.mem_wdata, 32'hDEADBEEF);
    step(); d_req = 0; #1;
    chk("t4_if_next", o.if_gnt, 1);
    chk("t4_if_wdata", o.mem_wdata, 0);
    step(); if_req = 0; #1;
    chk("t2_rvalid", o.if_rvalid, 1);
    chk("t2_rdata", o.if_rdata, 32'h00500093);
    chk("t2_no_drv", o.d_rvalid, 0);
    step();

    // T3: fairness with back-to-back stores against a held fetch
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h11;
    for (int i = 0; i < 7; i++) begin
      #1;
      dg[6-i] = o.d_gnt;
      ig[6-i] = o.if_gnt;
      step();
      if (dg[6-i]) begin d_addr = d_addr + 4; d_wdata = d_wdata + 1; end
    end
    chk("t3_d_order", {25'h0, dg}, 32'b1111001);
    chk("t3_if_order", {25'h0, ig}, 32'b0000100);
    idle_in(); step(); step();

    // run counter restarts when fetch drops its request for a cycle
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 1;
    for (int i = 0; i < 10; i++) begin
      if_req = (i != 3);
      step();
      d_addr = d_addr + 4;
    end
    idle_in(); step(); step();
    foreach (vl[i]) xfer(vl[i]);
    step(); step();

    // switch to the MEM_LAT=3 instance
    rst = 1; sel = 1; idle_in();
    step(); step();
    rst = 0;
    // T5
    d_req = 1; d_we = 0; d_addr = 32'h80; if_req = 1; if_addr = 32'h300; #1;
    chk("t5_dgnt", o.d_gnt, 1);
    step(); d_req = 0; #1;
    chk("t5_c1_nognt", o.if_gnt, 0);
    chk("t5_stall_if", o.stall_if, 1);
    step(); step(); #1;
    chk("t5_c3_rvalid", o.d_rvalid, 1);
    chk("t5_c3_rdata", o.d_rdata, 32'h0080FF7F);
    chk("t5_c3_nognt", o.if_gnt, 0);
    step(); #1;
    chk("t5_c4_ifgnt", o.if_gnt, 1);
    step(); if_req = 0;
    repeat (5) step();

    // T6: reset during an outstanding fetch
    if_req = 1; if_addr = 32'h400; #1;
    chk("t6_ifgnt", o.if_gnt, 1);
    step(); if_req = 0; rst = 1;
    step(); rst = 0; d_req = 1; d_we = 0; d_addr = 32'h88; #1;
    chk("t6_gnt_after_rst", o.d_gnt, 1);
    seen = 0;
    step(); d_req = 0;
    for (int i = 0; i < 6; i++) begin
      #1; seen = seen | o.if_rvalid;
      step();
    end
    chk("t6_no_if_rvalid", {31'h0, seen}, 0);
    foreach (vl[i]) xfer(vl[i]);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
